// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: watches a one-hot ring counter's output.
// It checks that each sampled value is one-hot and that the hot bit moved by exactly one place.
// It also decodes the hot bit into a binary phase index.
// Finally it counts full revolutions and error pulses.
module ring_phase_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned ALLOW_HOLD = 1,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned REV_CNT_W  = 16,
  localparam int unsigned PW        = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     ring_in,
  input  logic                 clear_err,
  output logic [PW-1:0]        phase_idx,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 onehot_err,
  output logic                 order_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [REV_CNT_W-1:0] rev_count
);

  typedef enum logic [0:0] {StSeek, StTrack} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [PW-1:0]        phase_idx_q, phase_idx_d;
  logic                 phase_valid_q, phase_valid_d;
  logic                 onehot_err_q, onehot_err_d;
  logic                 order_err_q, order_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [REV_CNT_W-1:0] rev_count_q, rev_count_d;

  logic             legal;
  logic             expected;
  logic [WIDTH-1:0] succ;
  logic [PW-1:0]    enc_idx;

  // Decode the sample: legality, binary position of the hot bit, and whether it follows prev.
  always_comb begin
    legal   = $onehot(ring_in);
    succ    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    enc_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) enc_idx = PW'(i);
    end
    expected = (ring_in == succ) || ((ALLOW_HOLD != 0) && (ring_in == prev_q));
  end

  // Next-state for the SEEK/TRACK FSM, decoded phase, error pulses and counters.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    phase_idx_d   = phase_idx_q;
    phase_valid_d = phase_valid_q;
    onehot_err_d  = 1'b0;
    order_err_d   = 1'b0;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    rev_count_d   = rev_count_q;

    if (en) begin
      if (!legal) begin
        onehot_err_d  = 1'b1;
        phase_valid_d = 1'b0;
        state_d       = StSeek;
      end else begin
        phase_idx_d   = enc_idx;
        phase_valid_d = 1'b1;
        // An unexpected but legal sample resyncs prev instead of dropping lock.
        prev_d        = ring_in;
        state_d       = StTrack;
        if (state_q == StTrack) begin
          order_err_d = !expected;
          if (prev_q[WIDTH-1] && ring_in[0]) rev_count_d = rev_count_q + REV_CNT_W'(1);
        end
      end
    end

    if (clear_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
    // A same-cycle error beats clear_err: the count restarts at one.
    if (onehot_err_d || order_err_d) begin
      err_sticky_d = 1'b1;
      if (clear_err) begin
        err_count_d = ERR_CNT_W'(1);
      end else if (err_count_q != {ERR_CNT_W{1'b1}}) begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StSeek;
      prev_q        <= '0;
      phase_idx_q   <= '0;
      phase_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
      order_err_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      rev_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      phase_idx_q   <= phase_idx_d;
      phase_valid_q <= phase_valid_d;
      onehot_err_q  <= onehot_err_d;
      order_err_q   <= order_err_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      rev_count_q   <= rev_count_d;
    end
  end

  assign phase_idx   = phase_idx_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == StTrack);
  assign onehot_err  = onehot_err_q;
  assign order_err   = order_err_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign rev_count   = rev_count_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor; a hold-allowed and a hold-forbidden instance share inputs.
module tb_ring_phase_monitor;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  ring_in;
  logic        clear_err;

  logic [1:0]  phase_idx,   phase_idx_nh;
  logic        phase_valid, phase_valid_nh;
  logic        locked,      locked_nh;
  logic        onehot_err,  onehot_err_nh;
  logic        order_err,   order_err_nh;
  logic        err_sticky,  err_sticky_nh;
  logic [7:0]  err_count,   err_count_nh;
  logic [15:0] rev_count,   rev_count_nh;

  int checks = 0;
  int errors = 0;

  ring_phase_monitor #(.WIDTH(4), .ALLOW_HOLD(1), .ERR_CNT_W(8), .REV_CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .en(en), .ring_in(ring_in), .clear_err(clear_err),
    .phase_idx(phase_idx), .phase_valid(phase_valid), .locked(locked),
    .onehot_err(onehot_err), .order_err(order_err), .err_sticky(err_sticky),
    .err_count(err_count), .rev_count(rev_count)
  );

  ring_phase_monitor #(.WIDTH(4), .ALLOW_HOLD(0), .ERR_CNT_W(8), .REV_CNT_W(16)) u_dut_nh (
    .clk(clk), .reset(reset), .en(en), .ring_in(ring_in), .clear_err(clear_err),
    .phase_idx(phase_idx_nh), .phase_valid(phase_valid_nh), .locked(locked_nh),
    .onehot_err(onehot_err_nh), .order_err(order_err_nh), .err_sticky(err_sticky_nh),
    .err_count(err_count_nh), .rev_count(rev_count_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, then look at the outputs 1 time unit after the capturing edge.
  task automatic step(input logic e, input logic [3:0] r, input logic c);
    en        = e;
    ring_in   = r;
    clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_phase(input string tag, input logic [1:0] idx, input logic lk);
    chk({tag, "_idx"}, 32'(phase_idx), 32'(idx));
    chk({tag, "_valid"}, 32'(phase_valid), 32'd1);
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
    chk({tag, "_pulses"}, {30'd0, onehot_err, order_err}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    ring_in   = 4'b0000;
    clear_err = 1'b0;
    #12;
    chk("rst_idx", 32'(phase_idx), 32'd0);
    chk("rst_valid", 32'(phase_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulses", {30'd0, onehot_err, order_err}, 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_rev", 32'(rev_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: lock and one full revolution.
    step(1'b1, 4'b0001, 1'b0);
    chk("s1_a_idx", 32'(phase_idx), 32'd0);
    step(1'b1, 4'b0001, 1'b0);
    chk_phase("s1_b", 2'd0, 1'b1);
    chk("s1_b_nh_order", 32'(order_err_nh), 32'd1);
    step(1'b1, 4'b0010, 1'b0);
    chk_phase("s1_c", 2'd1, 1'b1);
    step(1'b1, 4'b0100, 1'b0);
    chk_phase("s1_d", 2'd2, 1'b1);
    step(1'b1, 4'b1000, 1'b0);
    chk_phase("s1_e", 2'd3, 1'b1);
    chk("s1_e_rev", 32'(rev_count), 32'd0);
    step(1'b1, 4'b0001, 1'b0);
    chk_phase("s1_f", 2'd0, 1'b1);
    chk("s1_rev", 32'(rev_count), 32'd1);
    chk("s1_errcnt", 32'(err_count), 32'd0);
    chk("s1_sticky", 32'(err_sticky), 32'd0);
    chk("s1_nh_rev", 32'(rev_count_nh), 32'd1);

    // 2: two-hot sample drops lock, then relock.
    step(1'b1, 4'b0110, 1'b0);
    chk("s2_onehot", 32'(onehot_err), 32'd1);
    chk("s2_order", 32'(order_err), 32'd0);
    chk("s2_locked", 32'(locked), 32'd0);
    chk("s2_valid", 32'(phase_valid), 32'd0);
    chk("s2_idx_hold", 32'(phase_idx), 32'd0);
    chk("s2_errcnt", 32'(err_count), 32'd1);
    chk("s2_sticky", 32'(err_sticky), 32'd1);
    step(1'b1, 4'b0100, 1'b0);
    chk_phase("s2_relock", 2'd2, 1'b1);

    // 3: skip from 0010 to 1000 is an order error; lock kept, 0001 then counts a revolution.
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    chk("s3_rev_a", 32'(rev_count), 32'd2);
    step(1'b1, 4'b0010, 1'b0);
    chk_phase("s3_at2", 2'd1, 1'b1);
    step(1'b1, 4'b1000, 1'b0);
    chk("s3_order", 32'(order_err), 32'd1);
    chk("s3_onehot", 32'(onehot_err), 32'd0);
    chk("s3_locked", 32'(locked), 32'd1);
    chk("s3_idx", 32'(phase_idx), 32'd3);
    chk("s3_errcnt", 32'(err_count), 32'd2);
    step(1'b1, 4'b0001, 1'b0);
    chk_phase("s3_after", 2'd0, 1'b1);
    chk("s3_rev_b", 32'(rev_count), 32'd3);
    chk("s3_errcnt_b", 32'(err_count), 32'd2);

    // 4: repeat 0001 is legal only with hold allowed.
    step(1'b1, 4'b0001, 1'b0);
    chk("s4_hold_order", 32'(order_err), 32'd0);
    chk("s4_nh_order", 32'(order_err_nh), 32'd1);
    chk("s4_nh_locked", 32'(locked_nh), 32'd1);

    // 5: saturate the error counter, then clear against a simultaneous error, then clear alone.
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0000, 1'b0);
    chk("s5_sat", 32'(err_count), 32'd255);
    chk("s5_sat_sticky", 32'(err_sticky), 32'd1);
    step(1'b1, 4'b0000, 1'b1);
    chk("s5_clr_err_cnt", 32'(err_count), 32'd1);
    chk("s5_clr_err_sticky", 32'(err_sticky), 32'd1);
    chk("s5_clr_err_pulse", 32'(onehot_err), 32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("s5_clr_cnt", 32'(err_count), 32'd0);
    chk("s5_clr_sticky", 32'(err_sticky), 32'd0);
    chk("s5_clr_pulse", 32'(onehot_err), 32'd0);

    // 6: freeze with en low, then asynchronous reset mid-track.
    step(1'b1, 4'b0100, 1'b0);
    chk_phase("s6_lock", 2'd2, 1'b1);
    step(1'b0, 4'b0110, 1'b0);
    chk_phase("s6_frz_a", 2'd2, 1'b1);
    step(1'b0, 4'b1000, 1'b0);
    chk_phase("s6_frz_b", 2'd2, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    chk_phase("s6_frz_c", 2'd2, 1'b1);
    step(1'b0, 4'b1111, 1'b0);
    chk_phase("s6_frz_d", 2'd2, 1'b1);
    chk("s6_frz_rev", 32'(rev_count), 32'd3);
    chk("s6_frz_errcnt", 32'(err_count), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_rst_idx", 32'(phase_idx), 32'd0);
    chk("s6_rst_valid", 32'(phase_valid), 32'd0);
    chk("s6_rst_locked", 32'(locked), 32'd0);
    chk("s6_rst_rev", 32'(rev_count), 32'd0);
    chk("s6_rst_nh_rev", 32'(rev_count_nh), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'b1000, 1'b0);
    chk_phase("s6_post", 2'd3, 1'b1);
    chk("s6_post_rev", 32'(rev_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
